// File: rtl/cache_types_pkg.sv
// Shared types and geometry for the direct-mapped write-back cache.
// Optional statistics counters are enabled with the DM_CACHE_STATS_EN macro.
package cache_types_pkg;

    localparam int LINE_BITS      = 256;
    localparam int WORD_BITS      = 32;
    localparam int OFFSET_BITS    = 5;
    localparam int WORDS_PER_LINE = LINE_BITS / WORD_BITS;
    localparam int BYTES_PER_LINE = LINE_BITS / 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } cache_state_e;

    // Registered CPU request, captured when leaving IDLE.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } cpu_req_t;

    function automatic int index_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int num_sets);
        return 32 - OFFSET_BITS - $clog2(num_sets);
    endfunction

endpackage

// File: rtl/dm_wb_cache_if.sv
// CPU-side and line-side (cacheline adaptor) bus bundle for dm_wb_cache.
// slave is the cache's view; master is the view of the CPU plus adaptor.
interface dm_wb_cache_if;

    // CPU side
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    // Line side
    logic [31:0]                           pmem_address;
    logic                                  pmem_read;
    logic                                  pmem_write;
    logic [cache_types_pkg::LINE_BITS-1:0] pmem_wdata;
    logic [cache_types_pkg::LINE_BITS-1:0] pmem_rdata;
    logic                                  pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/cache_array.sv
// Tag, valid, dirty and line storage for the direct-mapped cache.
// Single index for read and write; reads are combinational, writes land
// on the rising edge with per-byte line enables. Only valid/dirty reset.
module cache_array
    import cache_types_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int IDX_W    = 3,
    parameter int TAG_W    = 24
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [IDX_W-1:0]          index,
    output logic [TAG_W-1:0]          rd_tag,
    output logic                      rd_valid,
    output logic                      rd_dirty,
    output logic [LINE_BITS-1:0]      rd_line,
    input  logic [BYTES_PER_LINE-1:0] line_we,
    input  logic [LINE_BITS-1:0]      line_wdata,
    input  logic                      tag_we,
    input  logic [TAG_W-1:0]          tag_wdata,
    input  logic                      meta_we,
    input  logic                      meta_valid,
    input  logic                      meta_dirty
);

    logic [LINE_BITS-1:0] data_mem [NUM_SETS];
    logic [TAG_W-1:0]     tag_mem  [NUM_SETS];
    logic [NUM_SETS-1:0]  valid_q;
    logic [NUM_SETS-1:0]  dirty_q;

    assign rd_tag   = tag_mem[index];
    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_line  = data_mem[index];

    // Line data: byte-granular write, deliberately not reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES_PER_LINE; b++) begin
            if (line_we[b]) data_mem[index][8*b +: 8] <= line_wdata[8*b +: 8];
        end
    end

    // Tag storage, deliberately not reset (valid bit gates its use).
    always_ff @(posedge clk) begin
        if (tag_we) tag_mem[index] <= tag_wdata;
    end

    // Valid/dirty bits: cleared asynchronously so a reset empties the cache.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (meta_we) begin
            valid_q[index] <= meta_valid;
            dirty_q[index] <= meta_dirty;
        end
    end

endmodule

// File: rtl/dm_wb_cache.sv
// Direct-mapped, write-back, write-allocate cache between a 32-bit CPU port
// and a 256-bit cacheline adaptor. Hits complete one cycle after the
// request is sampled; misses write back a dirty victim, then allocate.
// Define DM_CACHE_STATS_EN to add hit_count/miss_count outputs.
module dm_wb_cache
    import cache_types_pkg::*;
#(
    parameter int NUM_SETS = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    dm_wb_cache_if.slave  bus
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
`endif
);

    localparam int IDX_W = index_bits(NUM_SETS);
    localparam int TAG_W = tag_bits(NUM_SETS);

    cache_state_e state;
    cpu_req_t     req;
    logic         pmem_read_q;
    logic         pmem_write_q;
    logic [31:0]  pmem_address_q;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [2:0]       req_wsel;

    assign req_tag  = req.addr[31 -: TAG_W];
    assign req_idx  = req.addr[OFFSET_BITS +: IDX_W];
    assign req_wsel = req.addr[4:2];

    // Byte lane bits of the address never affect a word-wide access.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req.addr[1:0];

    // Array interface
    logic [TAG_W-1:0]          rd_tag;
    logic                      rd_valid;
    logic                      rd_dirty;
    logic [LINE_BITS-1:0]      rd_line;
    logic [BYTES_PER_LINE-1:0] line_we;
    logic [LINE_BITS-1:0]      line_wdata;
    logic                      tag_we;
    logic                      meta_we;
    logic                      meta_valid;
    logic                      meta_dirty;
    logic                      tag_match;

    cache_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_array (
        .clk        (clk),
        .reset_n    (reset_n),
        .index      (req_idx),
        .rd_tag     (rd_tag),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_line    (rd_line),
        .line_we    (line_we),
        .line_wdata (line_wdata),
        .tag_we     (tag_we),
        .tag_wdata  (req_tag),
        .meta_we    (meta_we),
        .meta_valid (meta_valid),
        .meta_dirty (meta_dirty)
    );

    assign tag_match = rd_valid && (rd_tag == req_tag);

    // CPU response is a pure function of the COMPARE state so it can never
    // stretch beyond the single COMPARE cycle.
    assign bus.mem_resp  = (state == COMPARE) && tag_match;
    assign bus.mem_rdata = rd_line[{req_wsel, 5'b0} +: WORD_BITS];

    // Victim line comes straight from the array; the set cannot change
    // while WRITEBACK is waiting, so the data stays stable.
    assign bus.pmem_wdata   = rd_line;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_address_q;

    // Array write controls: store-hit merge, dirty clear after writeback,
    // full-line fill on allocate. Only the accepted pmem_resp has effect.
    always_comb begin
        line_we    = '0;
        line_wdata = '0;
        tag_we     = 1'b0;
        meta_we    = 1'b0;
        meta_valid = 1'b0;
        meta_dirty = 1'b0;
        case (state)
            COMPARE: begin
                if (tag_match && req.we) begin
                    line_we[{req_wsel, 2'b00} +: 4] = req.be;
                    line_wdata = {WORDS_PER_LINE{req.wdata}};
                    meta_we    = 1'b1;
                    meta_valid = 1'b1;
                    meta_dirty = 1'b1;
                end
            end
            WRITEBACK: begin
                if (bus.pmem_resp) begin
                    meta_we    = 1'b1;
                    meta_valid = rd_valid;
                    meta_dirty = 1'b0;
                end
            end
            ALLOCATE: begin
                if (bus.pmem_resp) begin
                    line_we    = '1;
                    line_wdata = bus.pmem_rdata;
                    tag_we     = 1'b1;
                    meta_we    = 1'b1;
                    meta_valid = 1'b1;
                    meta_dirty = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Main controller: request capture, hit/miss decision, line transfers.
    // Line-side strobes and address are registered and held until pmem_resp.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            req            <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_read || bus.mem_write) begin
                        req.addr  <= bus.mem_address;
                        req.wdata <= bus.mem_wdata;
                        req.be    <= bus.mem_byte_enable;
                        req.we    <= bus.mem_write;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (tag_match) begin
                        state <= IDLE;
                    end else if (rd_valid && rd_dirty) begin
                        state          <= WRITEBACK;
                        pmem_write_q   <= 1'b1;
                        pmem_address_q <= {rd_tag, req_idx, {OFFSET_BITS{1'b0}}};
                    end else begin
                        state          <= ALLOCATE;
                        pmem_read_q    <= 1'b1;
                        pmem_address_q <= {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        state          <= ALLOCATE;
                        pmem_write_q   <= 1'b0;
                        pmem_read_q    <= 1'b1;
                        pmem_address_q <= {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
                    end
                end
                ALLOCATE: begin
                    if (bus.pmem_resp) begin
                        state       <= COMPARE;
                        pmem_read_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DM_CACHE_STATS_EN
    // Marks the COMPARE that follows a fill; that pass finishes an access
    // already counted as a miss, so it is not counted again as a hit.
    logic refill;

    // Track whether the current COMPARE is the post-fill re-check.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refill <= 1'b0;
        end else if (state == ALLOCATE && bus.pmem_resp) begin
            refill <= 1'b1;
        end else if (state == COMPARE) begin
            refill <= 1'b0;
        end
    end

    // Wrapping hit/miss counters, one step per first-pass COMPARE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == COMPARE) begin
            if (!tag_match)   miss_count <= miss_count + 32'd1;
            else if (!refill) hit_count  <= hit_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dm_wb_cache.sv
// Directed bench for dm_wb_cache: a line-side responder with programmable
// latency and a small backing store, plus CPU access tasks with
// hand-computed expectations.
module tb_dm_wb_cache;
    import cache_types_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dm_wb_cache_if bus();

`ifdef DM_CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dm_wb_cache #(.NUM_SETS(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef DM_CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Backing store: untouched lines hold word i = 0xC0DE0000 + line + 4*i.
    logic [255:0] mem_model [logic [31:0]];
    logic [32:0]  op_log [$];
    int           resp_delay = 0;
    int           rd_cnt = 0;
    int           wr_cnt = 0;
    logic [255:0] last_wb = '0;

    function automatic logic [255:0] pat_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'hC0DE_0000 + a + 32'(4 * i);
        return l;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return pat_line(a);
    endfunction

    // Line-side responder: holds pmem_resp off for resp_delay cycles while
    // checking that the request stays put, then completes it.
    initial begin
        logic         cap_rd, cap_wr, aborted;
        logic [31:0]  cap_addr;
        logic [255:0] cap_wdata;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset_n && (bus.pmem_read || bus.pmem_write)) begin
                cap_rd    = bus.pmem_read;
                cap_wr    = bus.pmem_write;
                cap_addr  = bus.pmem_address;
                cap_wdata = bus.pmem_wdata;
                aborted   = 1'b0;
                op_log.push_back({cap_wr, cap_addr});
                if (cap_wr) wr_cnt++; else rd_cnt++;
                for (int i = 0; i < resp_delay; i++) begin
                    @(negedge clk);
                    if (!reset_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    chk("pmem_hold", 256'({bus.pmem_read, bus.pmem_write, bus.pmem_address}),
                        256'({cap_rd, cap_wr, cap_addr}));
                    if (cap_wr) chk("pmem_wdata_hold", bus.pmem_wdata, cap_wdata);
                end
                if (!aborted) begin
                    if (cap_wr) begin
                        mem_model[cap_addr] = bus.pmem_wdata;
                        last_wb = bus.pmem_wdata;
                    end
                    bus.pmem_rdata = line_of(cap_addr);
                    bus.pmem_resp  = 1'b1;
                    @(negedge clk);
                    bus.pmem_resp  = 1'b0;
                    bus.pmem_rdata = '0;
                    chk("pmem_strobe_drop", 256'(cap_wr ? bus.pmem_write : bus.pmem_read), 256'(0));
                end
            end
        end
    end

    // Continuous protocol watch: exclusive strobes, single-cycle mem_resp.
    initial begin
        logic prev_resp;
        prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            chk("pmem_excl", 256'(bus.pmem_read & bus.pmem_write), 256'(0));
            chk("resp_pulse", 256'(prev_resp & bus.mem_resp), 256'(0));
            prev_resp = bus.mem_resp;
        end
    end

    task automatic cpu_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, output logic [31:0] rd, output int lat);
        logic got;
        @(negedge clk);
        bus.mem_address     = a;
        bus.mem_read        = !we;
        bus.mem_write       = we;
        bus.mem_wdata       = wd;
        bus.mem_byte_enable = be;
        lat = 0;
        got = 1'b0;
        rd  = 'x;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.mem_resp) begin
                rd  = bus.mem_rdata;
                got = 1'b1;
            end
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        chk("cpu_timeout", 256'(got), 256'(1));
    endtask

    // Read that must hit: data, one-cycle latency, no line traffic.
    task automatic rd_hit(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        int lat, ops;
        ops = op_log.size();
        cpu_access(1'b0, a, 32'h0, 4'h0, rd, lat);
        chk({tag, "_data"}, 256'(rd), 256'(exp));
        chk({tag, "_lat"}, 256'(lat), 256'(1));
        chk({tag, "_nopmem"}, 256'(op_log.size() - ops), 256'(0));
    endtask

    // Read that must miss into a clean/invalid set: one fill, 3-cycle latency.
    task automatic rd_miss(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        int lat, ops;
        ops = op_log.size();
        cpu_access(1'b0, a, 32'h0, 4'h0, rd, lat);
        chk({tag, "_data"}, 256'(rd), 256'(exp));
        chk({tag, "_lat"}, 256'(lat), 256'(3));
        chk({tag, "_nops"}, 256'(op_log.size() - ops), 256'(1));
        if (op_log.size() > ops) chk({tag, "_fill"}, 256'(op_log[ops]), 256'({1'b0, a[31:5], 5'b0}));
    endtask

    initial begin
        logic [31:0]  rd;
        logic [255:0] exp_line;
        int lat, ops;

        bus.mem_address = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.mem_wdata = '0; bus.mem_byte_enable = '0;
        exp_line = pat_line(32'h100);
        exp_line[63:32] = 32'hDEAD_BEEF;
        mem_model[32'h100] = exp_line;

        repeat (2) @(negedge clk);
        chk("rst_mem_resp", 256'(bus.mem_resp), 256'(0));
        chk("rst_pmem_strobes", 256'({bus.pmem_read, bus.pmem_write}), 256'(0));
        chk("rst_pmem_addr", 256'(bus.pmem_address), 256'(0));
`ifdef DM_CACHE_STATS_EN
        chk("rst_counts", 256'({hit_count, miss_count}), 256'(0));
`endif
        reset_n = 1'b1;

        // Cold fill, then a hit on the neighbouring word.
        resp_delay = 0;
        rd_miss("cold", 32'h0000_0100, 32'hC0DE_0100);
        rd_hit("hit_w1", 32'h0000_0104, 32'hDEAD_BEEF);

        // Partial store hit, read back merged word.
        ops = op_log.size();
        cpu_access(1'b1, 32'h0000_0104, 32'h1122_3344, 4'b0011, rd, lat);
        chk("wr_lat", 256'(lat), 256'(1));
        chk("wr_nopmem", 256'(op_log.size() - ops), 256'(0));
        rd_hit("merge", 32'h0000_0104, 32'hDEAD_3344);

        // Conflict on a dirty set with a long adaptor latency.
        resp_delay = 31;
        ops = op_log.size();
        cpu_access(1'b0, 32'h0000_1100, 32'h0, 4'h0, rd, lat);
        chk("evict_data", 256'(rd), 256'(32'hC0DE_1100));
        chk("evict_nops", 256'(op_log.size() - ops), 256'(2));
        if (op_log.size() >= ops + 2) begin
            chk("evict_wb_addr", 256'(op_log[ops]), 256'({1'b1, 32'h0000_0100}));
            chk("evict_fill_addr", 256'(op_log[ops + 1]), 256'({1'b0, 32'h0000_1100}));
        end
        exp_line = pat_line(32'h100);
        exp_line[63:32] = 32'hDEAD_3344;
        chk("evict_wb_line", last_wb, exp_line);

        // Clean victim now: refetch the written-back line, no writeback.
        resp_delay = 0;
        ops = wr_cnt;
        rd_miss("refetch", 32'h0000_0104, 32'hDEAD_3344);
        chk("refetch_no_wb", 256'(wr_cnt - ops), 256'(0));

        // Reset while ALLOCATE is waiting on the adaptor.
        resp_delay = 20;
        @(negedge clk);
        bus.mem_address = 32'h0000_3000;
        bus.mem_read    = 1'b1;
        repeat (4) @(negedge clk);
        chk("alloc_active", 256'({bus.pmem_read, bus.pmem_address}), 256'({1'b1, 32'h0000_3000}));
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_strobe", 256'({bus.pmem_read, bus.pmem_write}), 256'(0));
        chk("async_rst_addr", 256'(bus.pmem_address), 256'(0));
        bus.mem_read = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // After reset everything misses again; 3 misses + 5 hits.
        resp_delay = 0;
        rd_miss("post_rst", 32'h0000_3000, 32'hC0DE_3000);
        rd_hit("h1", 32'h0000_3004, 32'hC0DE_3004);
        rd_hit("h2", 32'h0000_3008, 32'hC0DE_3008);
        rd_miss("set1", 32'h0000_0020, 32'hC0DE_0020);
        rd_hit("h3", 32'h0000_0024, 32'hC0DE_0024);
        rd_miss("set2", 32'h0000_0040, 32'hC0DE_0040);
        rd_hit("h4", 32'h0000_0044, 32'hC0DE_0044);
        rd_hit("h5", 32'h0000_0048, 32'hC0DE_0048);
`ifdef DM_CACHE_STATS_EN
        chk("miss_count", 256'(miss_count), 256'(3));
        chk("hit_count", 256'(hit_count), 256'(5));
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
